// File: rtl/vp_cart_mapper.sv
// Cartridge ROM mapper: captures a download, sizes the image,
// then maps CPU cartridge accesses into ROM by bank lines.
module vp_cart_mapper #(
  parameter int ROM_AW = 16,
  parameter int CNT_W  = ROM_AW + 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ROM_AW-1:0] dl_addr,
  input  logic [11:0]       cart_a,
  input  logic [1:0]        cart_bs,
  input  logic              bank_we,
  input  logic [7:0]        bank_d,
  output logic [ROM_AW-1:0] rom_a,
  output logic [CNT_W-1:0]  cart_size,
  output logic [2:0]        map_mode,
  output logic              size_valid,
  output logic              dl_err
);

  localparam int BW = ROM_AW - 14;
  localparam logic [CNT_W-1:0] SAT = CNT_W'(2 ** ROM_AW);
  localparam logic [ROM_AW-1:0] MIN_MASK = ROM_AW'(2047);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CLASSIFY,
    RUN
  } state_t;

  state_t state, state_nx;

  logic              dl_active_d;
  logic              dl_rise;
  logic              dl_fall;
  logic [BW-1:0]     bank_reg;
  logic [ROM_AW-1:0] size_mask;
  logic [ROM_AW-1:0] rom_q;
  logic [ROM_AW-1:0] map_addr;
  logic [ROM_AW-1:0] mask_nx;
  logic [ROM_AW-1:0] cs_m1;
  logic [ROM_AW-1:0] eff_mask;
  logic [2:0]        eff_mode;
  logic [2:0]        mode_nx;
  logic              acc;
  logic              unused_bank;

  assign unused_bank = ^bank_d[7:BW];
  assign dl_rise = dl_active & ~dl_active_d;
  assign dl_fall = ~dl_active & dl_active_d;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = IDLE;
      LOAD:     if (dl_fall) state_nx = CLASSIFY;
      CLASSIFY: state_nx = RUN;
      RUN:      state_nx = RUN;
      default:  state_nx = IDLE;
    endcase
    if (dl_rise) state_nx = LOAD;
  end

  // Mask = next power of two at or above the size, minus one.
  always_comb begin
    mode_nx = 3'd4;
    if (cart_size <= CNT_W'(2048))       mode_nx = 3'd0;
    else if (cart_size <= CNT_W'(4096))  mode_nx = 3'd1;
    else if (cart_size <= CNT_W'(8192))  mode_nx = 3'd2;
    else if (cart_size <= CNT_W'(16384)) mode_nx = 3'd3;
    cs_m1 = '0;
    if (cart_size != '0) cs_m1 = ROM_AW'(cart_size - CNT_W'(1));
    acc = 1'b0;
    mask_nx = '0;
    for (int i = ROM_AW - 1; i >= 0; i--) begin
      acc = acc | cs_m1[i];
      mask_nx[i] = acc;
    end
    mask_nx = mask_nx | MIN_MASK;
  end

  always_comb begin
    eff_mode = (state == IDLE) ? 3'd0 : map_mode;
    eff_mask = (state == IDLE) ? MIN_MASK : size_mask;
    map_addr = '0;
    case (eff_mode)
      3'd0: map_addr[10:0] = {cart_a[11], cart_a[9:0]};
      3'd1: map_addr[11:0] = {cart_bs[0], cart_a[11], cart_a[9:0]};
      3'd2: map_addr[12:0] = {cart_bs, cart_a[11], cart_a[9:0]};
      3'd3: map_addr[13:0] = {cart_bs, cart_a};
      default: map_addr = {bank_reg, cart_bs, cart_a};
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_active_d <= 1'b0;
      cart_size   <= '0;
      map_mode    <= 3'd0;
      size_valid  <= 1'b0;
      dl_err      <= 1'b0;
      bank_reg    <= '0;
      size_mask   <= MIN_MASK;
      rom_q       <= '0;
    end else begin
      dl_active_d <= dl_active;
      rom_q       <= map_addr & eff_mask;
      if (dl_rise) begin
        cart_size  <= '0;
        dl_err     <= 1'b0;
        size_valid <= 1'b0;
        bank_reg   <= '0;
      end else begin
        if (state == LOAD && dl_wr) begin
          if (cart_size == SAT) dl_err <= 1'b1;
          else                  cart_size <= cart_size + CNT_W'(1);
        end
        if (state == CLASSIFY) begin
          map_mode   <= mode_nx;
          size_mask  <= mask_nx;
          size_valid <= (cart_size != '0);
        end
        if (state == RUN && bank_we && map_mode == 3'd4)
          bank_reg <= bank_d[BW-1:0];
      end
    end
  end

  assign rom_a = (state == LOAD) ? dl_addr : rom_q;

endmodule

// File: tb/tb_vp_cart_mapper.sv
// Self-checking bench for vp_cart_mapper: vector table, directed
// corner sequences and randomized downloads against a size model.
`timescale 1ns/1ps
module tb_vp_cart_mapper;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active, dl_wr, bank_we;
  logic [15:0] dl_addr;
  logic [11:0] cart_a;
  logic [1:0]  cart_bs;
  logic [7:0]  bank_d;
  logic [15:0] rom_a;
  logic [16:0] cart_size;
  logic [2:0]  map_mode;
  logic        size_valid, dl_err;

  logic        s_reset;
  logic        s_dl_active, s_dl_wr, s_bank_we;
  logic [15:0] s_dl_addr;
  logic [11:0] s_cart_a;
  logic [1:0]  s_cart_bs;
  logic [7:0]  s_bank_d;
  logic [15:0] s_rom_a;
  logic [16:0] s_cart_size;
  logic [2:0]  s_map_mode;
  logic        s_size_valid, s_dl_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  vp_cart_mapper u_dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .cart_a(cart_a), .cart_bs(cart_bs),
    .bank_we(bank_we), .bank_d(bank_d),
    .rom_a(rom_a), .cart_size(cart_size), .map_mode(map_mode),
    .size_valid(size_valid), .dl_err(dl_err)
  );

  vp_cart_mapper u_sat (
    .clk_sys(clk_sys), .reset(s_reset),
    .dl_active(s_dl_active), .dl_wr(s_dl_wr), .dl_addr(s_dl_addr),
    .cart_a(s_cart_a), .cart_bs(s_cart_bs),
    .bank_we(s_bank_we), .bank_d(s_bank_d),
    .rom_a(s_rom_a), .cart_size(s_cart_size), .map_mode(s_map_mode),
    .size_valid(s_size_valid), .dl_err(s_dl_err)
  );

  typedef struct {
    int          nwr;
    logic [1:0]  bs;
    logic [11:0] a;
    logic [2:0]  mode;
    logic        valid;
    logic [15:0] rom;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int ref_mode(input int n);
    if (n <= 2048) return 0;
    if (n <= 4096) return 1;
    if (n <= 8192) return 2;
    if (n <= 16384) return 3;
    return 4;
  endfunction

  function automatic int ref_mask(input int n);
    int p = 2048;
    while (p < n) p = p * 2;
    return p - 1;
  endfunction

  function automatic int ref_map(input int mode, input int bank,
                                 input int bs, input int a);
    int a11 = (a / 2048) % 2;
    int lo  = a % 1024;
    int r;
    case (mode)
      0: r = a11 * 1024 + lo;
      1: r = (bs % 2) * 2048 + a11 * 1024 + lo;
      2: r = bs * 2048 + a11 * 1024 + lo;
      3: r = bs * 4096 + a;
      default: r = bank * 16384 + bs * 4096 + a;
    endcase
    return r % 65536;
  endfunction

  task automatic dl_run(input int n);
    dl_active = 1'b1;
    dl_wr = 1'b0;
    tick();
    dl_addr = 16'($urandom);
    #1;
    chk("rom_a_load_passthru", rom_a, dl_addr);
    for (int i = 0; i < n; i++) begin
      dl_wr = 1'b1;
      dl_addr = 16'(i);
      tick();
    end
    dl_wr = 1'b0;
    dl_active = 1'b0;
    tick();
    tick();
  endtask

  task automatic map_chk(input string nm, input logic [1:0] bs,
                         input logic [11:0] a, input logic [15:0] exp);
    cart_bs = bs;
    cart_a = a;
    tick();
    chk(nm, rom_a, exp);
  endtask

  task automatic main_seq();
    int n, m, mask, bank, bs, a;
    logic [7:0] bd;

    map_chk("idle_mode0_map", 2'b11, 12'hFFF, 16'h07FF);

    foreach (tbl[k]) begin
      dl_run(tbl[k].nwr);
      chk($sformatf("tbl%0d_size", k), cart_size, tbl[k].nwr);
      chk($sformatf("tbl%0d_mode", k), map_mode, tbl[k].mode);
      chk($sformatf("tbl%0d_valid", k), size_valid, tbl[k].valid);
      map_chk($sformatf("tbl%0d_rom", k), tbl[k].bs, tbl[k].a,
              tbl[k].rom);
    end

    dl_run(32768);
    chk("m4_size", cart_size, 17'h08000);
    chk("m4_mode", map_mode, 3'd4);
    bank_d = 8'h01;
    bank_we = 1'b1;
    tick();
    bank_we = 1'b0;
    map_chk("m4_bank1", 2'b00, 12'h123, 16'h4123);
    bank_d = 8'h03;
    bank_we = 1'b1;
    tick();
    bank_we = 1'b0;
    map_chk("m4_bank3_masked", 2'b00, 12'h123, 16'h4123);

    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? 0 : int'($urandom_range(1, 5000));
      dl_run(n);
      m = ref_mode(n);
      mask = ref_mask(n);
      bank = 0;
      chk("rnd_size", cart_size, n);
      chk("rnd_mode", map_mode, m);
      chk("rnd_valid", size_valid, n != 0);
      for (int j = 0; j < 20; j++) begin
        bs = int'($urandom_range(0, 3));
        a = int'($urandom_range(0, 4095));
        bd = 8'($urandom);
        bank_we = ($urandom_range(0, 3) == 0);
        bank_d = bd;
        cart_bs = 2'(bs);
        cart_a = 12'(a);
        tick();
        chk("rnd_rom", rom_a, ref_map(m, bank, bs, a) & mask);
        if (bank_we && m == 4) bank = bd % 4;
        bank_we = 1'b0;
      end
    end

    dl_active = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      dl_wr = 1'b1;
      tick();
    end
    dl_wr = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstload_size", cart_size, 0);
    chk("rstload_mode", map_mode, 0);
    chk("rstload_valid", size_valid, 0);
    chk("rstload_err", dl_err, 0);
    chk("rstload_rom", rom_a, 0);
    dl_active = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("rstload_no_classify_valid", size_valid, 0);
    chk("rstload_no_classify_mode", map_mode, 0);
    map_chk("rstload_idle_map", 2'b11, 12'hFFF, 16'h07FF);
  endtask

  task automatic sat_seq();
    s_dl_active = 1'b1;
    tick();
    for (int i = 0; i < 65536; i++) begin
      s_dl_wr = 1'b1;
      tick();
    end
    s_dl_wr = 1'b0;
    tick();
    chk("sat_at_limit_size", s_cart_size, 17'h10000);
    chk("sat_at_limit_err", s_dl_err, 0);
    s_dl_wr = 1'b1;
    tick();
    s_dl_wr = 1'b0;
    s_dl_active = 1'b0;
    tick();
    tick();
    chk("sat_size", s_cart_size, 17'h10000);
    chk("sat_err", s_dl_err, 1);
    chk("sat_mode", s_map_mode, 3'd4);
    s_dl_active = 1'b1;
    tick();
    chk("sat_err_clear", s_dl_err, 0);
    chk("sat_size_clear", s_cart_size, 0);
    s_dl_active = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{4096,  2'b01, 12'h805, 3'd1, 1'b1, 16'h0C05};
    tbl[1] = '{3000,  2'b01, 12'hBFF, 3'd1, 1'b1, 16'h0FFF};
    tbl[2] = '{12288, 2'b11, 12'hFFF, 3'd3, 1'b1, 16'h3FFF};
    tbl[3] = '{0,     2'b11, 12'hFFF, 3'd0, 1'b0, 16'h07FF};
    tbl[4] = '{2048,  2'b10, 12'h5AB, 3'd0, 1'b1, 16'h01AB};

    reset = 1'b1;
    s_reset = 1'b1;
    dl_active = 1'b0;
    dl_wr = 1'b0;
    dl_addr = '0;
    cart_a = '0;
    cart_bs = '0;
    bank_we = 1'b0;
    bank_d = '0;
    s_dl_active = 1'b0;
    s_dl_wr = 1'b0;
    s_dl_addr = '0;
    s_cart_a = '0;
    s_cart_bs = '0;
    s_bank_we = 1'b0;
    s_bank_d = '0;
    #1;
    chk("rst_rom", rom_a, 0);
    chk("rst_size", cart_size, 0);
    chk("rst_mode", map_mode, 0);
    chk("rst_valid", size_valid, 0);
    chk("rst_err", dl_err, 0);
    tick();
    tick();
    reset = 1'b0;
    s_reset = 1'b0;
    tick();

    fork
      main_seq();
      sat_seq();
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
